// File: rtl/pipe_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_unit_if
// Brief    : ID-side hazard request/response bundle for pipe_hazard_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_hazard_unit_if #(
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 3,
   parameter int CNT_W   = 16
);
   localparam int c_FSW = $clog2(DEPTH + 1);

   logic                        id_valid_i;
   logic [NUM_SRC*REG_AW-1:0]   id_rs_addr_i;
   logic [NUM_SRC-1:0]          id_rs_used_i;
   logic [REG_AW-1:0]           id_rd_addr_i;
   logic                        id_regwrite_i;
   logic                        id_memread_i;
   logic                        flush_i;
   logic                        stall_o;
   logic [NUM_SRC*c_FSW-1:0]    fwd_sel_o;
   logic [DEPTH-1:0]            stage_valid_o;
   logic [CNT_W-1:0]            stall_cnt_o;

   modport master (
      output id_valid_i, id_rs_addr_i, id_rs_used_i, id_rd_addr_i,
             id_regwrite_i, id_memread_i, flush_i,
      input  stall_o, fwd_sel_o, stage_valid_o, stall_cnt_o
   );

   modport slave (
      input  id_valid_i, id_rs_addr_i, id_rs_used_i, id_rd_addr_i,
             id_regwrite_i, id_memread_i, flush_i,
      output stall_o, fwd_sel_o, stage_valid_o, stall_cnt_o
   );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_unit
// Brief    : RAW hazard tracker giving stall, forwarding selects and flush
//            bubbles for an in-order pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_unit #(
   parameter int REG_AW       = 5,
   parameter int NUM_SRC      = 2,
   parameter int DEPTH        = 3,
   parameter int FWD_EN       = 1,
   parameter int FLUSH_STAGES = 1,
   parameter int CNT_W        = 16
) (
   input  wire logic          clk_i,
   input  wire logic          rst_i,
   pipe_hazard_unit_if.slave  bus
);
   localparam int c_FSW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0]          r_valid;
   logic [REG_AW-1:0]         r_rd [DEPTH];
   logic [DEPTH-1:0]          r_regwrite;
   logic [DEPTH-1:0]          r_memread;
   logic [CNT_W-1:0]          r_stall_cnt;

   logic [REG_AW-1:0]         w_rs;
   logic                      w_hit;
   int                        w_idx;
   logic [NUM_SRC-1:0]        w_any;
   logic [NUM_SRC-1:0]        w_load_use;
   logic [NUM_SRC*c_FSW-1:0]  w_fwd_sel;
   logic                      w_stall;

   // Scan oldest to youngest so the youngest matching stage overwrites last.
   always_comb begin
      w_rs       = '0;
      w_hit      = 1'b0;
      w_idx      = 0;
      w_any      = '0;
      w_load_use = '0;
      w_fwd_sel  = '0;
      for (int j = 0; j < NUM_SRC; j++) begin
         w_rs  = bus.id_rs_addr_i[j*REG_AW +: REG_AW];
         w_hit = 1'b0;
         w_idx = 0;
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (bus.id_valid_i && bus.id_rs_used_i[j] && (w_rs != '0) &&
                r_valid[k] && r_regwrite[k] && (r_rd[k] == w_rs)) begin
               w_hit = 1'b1;
               w_idx = k;
            end
         end
         if (w_hit) begin
            w_any[j] = 1'b1;
            if ((w_idx == 0) && r_memread[0]) begin
               w_load_use[j] = 1'b1;
            end
            w_fwd_sel[j*c_FSW +: c_FSW] = c_FSW'(w_idx + 1);
         end
      end
   end

   always_comb begin
      w_stall = 1'b0;
      if (!bus.flush_i) begin
         w_stall = (FWD_EN != 0) ? (|w_load_use) : (|w_any);
      end
   end

   assign bus.stall_o       = w_stall;
   assign bus.fwd_sel_o     = ((FWD_EN != 0) && !bus.flush_i) ? w_fwd_sel : '0;
   assign bus.stage_valid_o = r_valid;
   assign bus.stall_cnt_o   = r_stall_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid     <= '0;
         r_regwrite  <= '0;
         r_memread   <= '0;
         r_stall_cnt <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            r_rd[k] <= '0;
         end
      end else begin
         r_valid[0]    <= bus.id_valid_i & ~w_stall & ~bus.flush_i;
         r_rd[0]       <= bus.id_rd_addr_i;
         r_regwrite[0] <= bus.id_regwrite_i;
         r_memread[0]  <= bus.id_memread_i;
         // Stages fed by a squashed young stage become bubbles.
         for (int k = 1; k < DEPTH; k++) begin
            r_valid[k]    <= r_valid[k-1] & ~(bus.flush_i & (k <= FLUSH_STAGES));
            r_rd[k]       <= r_rd[k-1];
            r_regwrite[k] <= r_regwrite[k-1];
            r_memread[k]  <= r_memread[k-1];
         end
         if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
      end
   end
endmodule
`default_nettype wire
